// File: rtl/simt_pkg.sv
// rtl/simt_pkg.sv - shared SIMT types and defaults used by the frame launch controller
//
// Purpose: holds the frame launch sequencer state encoding and the default
// framebuffer geometry so the sequencer and its users agree on them.
// Ports: none (package).
package simt_pkg;

  typedef enum logic [3:0] {
    FS_IDLE   = 4'd0,
    FS_SMRST  = 4'd1,
    FS_SETTLE = 4'd2,
    FS_SETUP0 = 4'd3,
    FS_SETUP1 = 4'd4,
    FS_CLEAR  = 4'd5,
    FS_LAUNCH = 4'd6,
    FS_RUN    = 4'd7,
    FS_DONE   = 4'd8
  } frame_ctrl_state_e;

  localparam logic [31:0] FB_BASE_DEFAULT  = 32'h0000_2000;
  localparam int unsigned FB_WORDS_DEFAULT = 128;

endpackage

// File: rtl/frame_launch_ctrl.sv
// rtl/frame_launch_ctrl.sv - per-frame reset/seed/clear/launch sequencer for the SM
//
// Purpose: for each of NUM_FRAMES frames, resets the SM, seeds the zero and
// angle registers, clears the framebuffer, launches warp 0 and waits for it
// to exit (or time out), then reports the frame and advances the angle.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin a run (sampled in IDLE only)
//   busy              high whenever not IDLE
//   sm_rst_n          active-low reset to the SM
//   rf_wr_*           register-file write port (warp 0, lane 0)
//   mem_wr_*          framebuffer clear writes, valid/ready handshake
//   launch, launch_*  one-cycle warp 0 launch with PC and active mask
//   warp_exit         level, warp 0 has exited
//   frame_done        one-cycle pulse per finished frame, with frame_idx
//   all_done          one-cycle pulse after the last frame
//   timeout_err       sticky RUN timeout flag, cleared by start
module frame_launch_ctrl
  import simt_pkg::*;
#(
  parameter int unsigned NUM_FRAMES    = 48,
  parameter logic [31:0] FB_BASE       = FB_BASE_DEFAULT,
  parameter int unsigned FB_WORDS      = FB_WORDS_DEFAULT,
  parameter logic [15:0] ANGLE_STEP    = 16'h0555,
  parameter logic [7:0]  ANGLE_REG     = 8'd15,
  parameter logic [7:0]  ZERO_REG      = 8'd20,
  parameter int unsigned RESET_CYCLES  = 10,
  parameter int unsigned SETTLE_CYCLES = 5,
  parameter logic [31:0] START_PC      = 32'h0,
  parameter logic [31:0] LAUNCH_MASK   = 32'h1,
  parameter int unsigned TIMEOUT       = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        sm_rst_n,
  output logic        rf_wr_en,
  output logic [7:0]  rf_wr_reg,
  output logic [31:0] rf_wr_data,
  output logic        mem_wr_valid,
  input  logic        mem_wr_ready,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        launch,
  output logic [31:0] launch_pc,
  output logic [31:0] launch_mask,
  input  logic        warp_exit,
  output logic        frame_done,
  output logic [7:0]  frame_idx,
  output logic        all_done,
  output logic        timeout_err
);

  frame_ctrl_state_e state;

  // Shared down-counter for SMRST, SETTLE and RUN durations.
  logic [31:0] cnt;
  logic [31:0] word_idx;
  logic [15:0] angle;

  logic last_word;
  logic last_frame;
  logic run_first;

  assign last_word  = (word_idx == FB_WORDS - 1);
  assign last_frame = (frame_idx == 8'(NUM_FRAMES - 1));
  // The counter is loaded with TIMEOUT-1 on launch, so this value marks the
  // first RUN cycle, where a stale exit from the previous frame may linger.
  assign run_first  = (cnt == TIMEOUT - 1);

  assign mem_wr_data = 32'h0;
  assign launch_pc   = START_PC;
  assign launch_mask = LAUNCH_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FS_IDLE;
      busy         <= 1'b0;
      sm_rst_n     <= 1'b0;
      rf_wr_en     <= 1'b0;
      rf_wr_reg    <= 8'h0;
      rf_wr_data   <= 32'h0;
      mem_wr_valid <= 1'b0;
      mem_wr_addr  <= 32'h0;
      launch       <= 1'b0;
      frame_done   <= 1'b0;
      frame_idx    <= 8'h0;
      all_done     <= 1'b0;
      timeout_err  <= 1'b0;
      cnt          <= 32'h0;
      word_idx     <= 32'h0;
      angle        <= 16'h0;
    end else begin
      launch     <= 1'b0;
      frame_done <= 1'b0;
      all_done   <= 1'b0;

      case (state)
        FS_IDLE: begin
          sm_rst_n <= 1'b1;
          if (start) begin
            state       <= FS_SMRST;
            busy        <= 1'b1;
            sm_rst_n    <= 1'b0;
            frame_idx   <= 8'h0;
            angle       <= 16'h0;
            timeout_err <= 1'b0;
            cnt         <= RESET_CYCLES - 1;
          end
        end

        FS_SMRST: begin
          if (cnt == 32'h0) begin
            state    <= FS_SETTLE;
            sm_rst_n <= 1'b1;
            cnt      <= SETTLE_CYCLES - 1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        FS_SETTLE: begin
          if (cnt == 32'h0) begin
            state      <= FS_SETUP0;
            rf_wr_en   <= 1'b1;
            rf_wr_reg  <= ZERO_REG;
            rf_wr_data <= 32'h0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        FS_SETUP0: begin
          state      <= FS_SETUP1;
          rf_wr_reg  <= ANGLE_REG;
          rf_wr_data <= {16'h0, angle};
        end

        FS_SETUP1: begin
          state        <= FS_CLEAR;
          rf_wr_en     <= 1'b0;
          mem_wr_valid <= 1'b1;
          mem_wr_addr  <= FB_BASE;
          word_idx     <= 32'h0;
        end

        FS_CLEAR: begin
          // Address only moves on an accepted beat, so it holds under backpressure.
          if (mem_wr_valid && mem_wr_ready) begin
            if (last_word) begin
              state        <= FS_LAUNCH;
              mem_wr_valid <= 1'b0;
              launch       <= 1'b1;
            end else begin
              word_idx    <= word_idx + 32'd1;
              mem_wr_addr <= mem_wr_addr + 32'd4;
            end
          end
        end

        FS_LAUNCH: begin
          state <= FS_RUN;
          cnt   <= TIMEOUT - 1;
        end

        FS_RUN: begin
          if (warp_exit && !run_first) begin
            state      <= FS_DONE;
            frame_done <= 1'b1;
          end else if (cnt == 32'h0) begin
            state       <= FS_DONE;
            frame_done  <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        FS_DONE: begin
          if (last_frame) begin
            state    <= FS_IDLE;
            busy     <= 1'b0;
            all_done <= 1'b1;
          end else begin
            state     <= FS_SMRST;
            sm_rst_n  <= 1'b0;
            cnt       <= RESET_CYCLES - 1;
            frame_idx <= frame_idx + 8'd1;
            angle     <= angle + ANGLE_STEP;
          end
        end

        default: begin
          state <= FS_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_launch_ctrl.sv
// tb/tb_frame_launch_ctrl.sv - randomized self-checking bench for frame_launch_ctrl
module tb_frame_launch_ctrl;

  localparam int NF       = 48;
  localparam int TO       = 100;
  localparam int WORDS    = 128;
  localparam logic [31:0] BASE = 32'h0000_2000;
  // Cycles from the start (or DONE) cycle to the LAUNCH cycle with ready held high.
  localparam int OVERHEAD = 10 + 5 + 2 + WORDS + 1;

  localparam int EX_NORMAL  = 0;
  localparam int EX_TIMEOUT = 1;
  localparam int EX_STUCK   = 2;
  localparam int RDY_ONE    = 0;
  localparam int RDY_TOGGLE = 1;
  localparam int RDY_RANDOM = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mem_wr_ready = 1'b1;
  logic        warp_exit = 1'b0;
  logic        busy, sm_rst_n, rf_wr_en, mem_wr_valid, launch;
  logic        frame_done, all_done, timeout_err;
  logic [7:0]  rf_wr_reg, frame_idx;
  logic [31:0] rf_wr_data, mem_wr_addr, mem_wr_data, launch_pc, launch_mask;

  frame_launch_ctrl #(.NUM_FRAMES(NF), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .sm_rst_n(sm_rst_n),
    .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .launch(launch), .launch_pc(launch_pc), .launch_mask(launch_mask),
    .warp_exit(warp_exit), .frame_done(frame_done), .frame_idx(frame_idx),
    .all_done(all_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-frame environment behaviour, indexed by the frame the model expects.
  int exit_mode [NF];
  int exit_dly  [NF];
  int rdy_mode  [NF];
  int k = 0;

  // Memory ready and a behavioural warp 0: exits exit_dly cycles after launch.
  int exit_cnt = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode[k])
      RDY_ONE:    mem_wr_ready = 1'b1;
      RDY_TOGGLE: mem_wr_ready = ~mem_wr_ready;
      default:    mem_wr_ready = 1'($urandom_range(0, 1));
    endcase
    if (launch) begin
      exit_cnt = 0;
      case (exit_mode[k])
        EX_STUCK:   warp_exit = 1'b1;
        EX_TIMEOUT: warp_exit = 1'b0;
        default: begin
          warp_exit = 1'b0;
          exit_cnt  = exit_dly[k];
        end
      endcase
    end else if (exit_cnt > 0) begin
      exit_cnt--;
      if (exit_cnt == 0) warp_exit = 1'b1;
    end
  end

  // Reference model / scoreboard.
  int cyc = 0, seg_start = 0, launch_cyc = 0, rf_n = 0, words = 0;
  int n_launch = 0, low_n = 0, exp_lat = 0;
  bit exp_terr = 1'b0, prev_busy = 1'b0, pend_all = 1'b0, hold_pend = 1'b0;
  logic [31:0] hold_addr = 32'h0;
  logic [15:0] exp_angle;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      k = 0; rf_n = 0; words = 0; n_launch = 0; low_n = 0;
      prev_busy = 1'b0; pend_all = 1'b0; hold_pend = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        k = 0; exp_terr = 1'b0; seg_start = cyc - 1;
        rf_n = 0; words = 0; n_launch = 0; low_n = 0;
        check_eq("start_terr_clr", timeout_err, 0);
        check_eq("start_smrst", sm_rst_n, 0);
      end
      check_eq("all_done", all_done, pend_all);
      if (pend_all) begin
        check_eq("idle_after_all", busy, 0);
        pend_all = 1'b0;
      end
      if (busy && !sm_rst_n) low_n++;
      if (rf_wr_en) begin
        rf_n++;
        check_eq("rf_idx", frame_idx, k);
        if (rf_n == 1) begin
          check_eq("rf0_reg", rf_wr_reg, 20);
          check_eq("rf0_data", rf_wr_data, 0);
        end else begin
          exp_angle = 16'(k * 32'h555);
          check_eq("rf1_reg", rf_wr_reg, 15);
          check_eq("rf1_data", rf_wr_data, {16'h0, exp_angle});
          if (k == NF - 1) check_eq("angle_last", rf_wr_data, 32'h0000_FA9B);
        end
      end
      if (hold_pend) begin
        check_eq("hold_valid", mem_wr_valid, 1);
        check_eq("hold_addr", mem_wr_addr, hold_addr);
      end
      if (mem_wr_valid && mem_wr_ready) begin
        check_eq("wr_addr", mem_wr_addr, BASE + 4 * words);
        check_eq("wr_data", mem_wr_data, 0);
        words++;
      end
      hold_pend = mem_wr_valid && !mem_wr_ready;
      hold_addr = mem_wr_addr;
      if (launch) begin
        n_launch++;
        check_eq("words", words, WORDS);
        check_eq("rf_writes", rf_n, 2);
        check_eq("rst_low", low_n, 10);
        check_eq("launch_pc", launch_pc, 0);
        check_eq("launch_mask", launch_mask, 1);
        if (rdy_mode[k] == RDY_ONE) check_eq("overhead", cyc - seg_start, OVERHEAD);
        launch_cyc = cyc;
      end
      if (frame_done) begin
        case (exit_mode[k])
          EX_TIMEOUT: begin exp_lat = TO + 1; exp_terr = 1'b1; end
          EX_STUCK:   exp_lat = 3;
          default:    exp_lat = exit_dly[k] + 1;
        endcase
        check_eq("fd_idx", frame_idx, k);
        check_eq("fd_lat", cyc - launch_cyc, exp_lat);
        check_eq("fd_terr", timeout_err, exp_terr);
        check_eq("fd_launches", n_launch, 1);
        seg_start = cyc; rf_n = 0; words = 0; n_launch = 0; low_n = 0;
        if (k == NF - 1) pend_all = 1'b1;
        else k++;
      end
      prev_busy = busy;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_all(input int budget);
    int n = 0;
    while (!all_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("run_complete", all_done, 1);
  endtask

  task automatic check_rst_vals();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_sm_rst_n", sm_rst_n, 0);
    check_eq("rst_rf_wr_en", rf_wr_en, 0);
    check_eq("rst_mem_wr_valid", mem_wr_valid, 0);
    check_eq("rst_launch", launch, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_all_done", all_done, 0);
    check_eq("rst_frame_idx", frame_idx, 0);
    check_eq("rst_timeout_err", timeout_err, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NF; i++) begin
      exit_mode[i] = EX_NORMAL;
      exit_dly[i]  = $urandom_range(2, 40);
      rdy_mode[i]  = RDY_ONE;
    end
    exit_dly[0]  = 20;
    rdy_mode[1]  = RDY_TOGGLE;
    rdy_mode[2]  = RDY_RANDOM;
    exit_mode[3] = EX_TIMEOUT;
    exit_mode[4] = EX_STUCK;
    exit_mode[5] = EX_TIMEOUT;
    rdy_mode[6]  = RDY_RANDOM;
    exit_dly[7]  = 2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rst_vals();
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_sm_rst_n", sm_rst_n, 1);
    check_eq("idle_busy", busy, 0);

    // Run 1: mixed environment, plus a start pulse while busy that must be ignored.
    pulse_start();
    n = 0;
    while (k < 10 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_frame10", k, 10);
    pulse_start();
    wait_all(30000);
    @(negedge clk);

    // Run 2: start clears the sticky timeout; reset lands mid-CLEAR at word 50.
    for (int i = 0; i < NF; i++) begin
      exit_mode[i] = EX_NORMAL;
      exit_dly[i]  = $urandom_range(2, 5);
      rdy_mode[i]  = RDY_ONE;
    end
    pulse_start();
    n = 0;
    while (!(mem_wr_valid && mem_wr_addr == BASE + 32'd200) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_word50", mem_wr_addr, BASE + 32'd200);
    rst = 1'b1;
    @(negedge clk);
    check_rst_vals();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_idle", busy, 0);

    // Run 3: full run from frame 0, word 0.
    pulse_start();
    wait_all(20000);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
